// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling,
// framing-error and overrun reporting, valid/ack holding register.
module uart_rx #(
  parameter int TicksPerBaud = 0,
  parameter bit InvertData   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx,
  input  logic       ack,
  output logic       stb,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = (TicksPerBaud < 4) ? 2 : $clog2(TicksPerBaud);
  localparam logic [CW-1:0] HALF = CW'(TicksPerBaud / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(TicksPerBaud - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shf_q, shf_d;
  logic [7:0]      data_q, data_d;
  logic            stb_q, stb_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic            sync1_q;
  logic            rx_s_q;

  // Two-flop synchroniser for the asynchronous line, idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // State, counters, shift register and output holding register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      data_q  <= '0;
      stb_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  // Frame sequencing, bit sampling and delivery decisions.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shf_d   = shf_q;
    data_d  = data_q;
    stb_d   = stb_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    if (stb_q && ack) begin
      stb_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_q == HALF) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == FULL) begin
          baud_d = '0;
          shf_d  = {rx_s_q, shf_q[7:1]};
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == FULL) begin
          baud_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            if (!stb_q || ack) begin
              data_d = shf_q ^ {8{InvertData}};
              stb_d  = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign stb       = stb_q;
  assign data      = data_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at 16 ticks per bit,
// plus a second instance with inverted data.
module tb_uart_rx;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic       ack2 = 1'b0;
  logic       stb, stb2;
  logic [7:0] data, data2;
  logic       fe, fe2, ov, ov2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int t_rise = -1;
  logic stb_prev = 1'b0;
  int t0;
  int ov_base;

  always #5 clk = ~clk;

  uart_rx #(.TicksPerBaud(T), .InvertData(1'b0)) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rx       (rx),
    .ack      (ack),
    .stb      (stb),
    .data     (data),
    .frame_err(fe),
    .overrun  (ov)
  );

  uart_rx #(.TicksPerBaud(T), .InvertData(1'b1)) u_inv (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rx       (rx),
    .ack      (ack2),
    .stb      (stb2),
    .data     (data2),
    .frame_err(fe2),
    .overrun  (ov2)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fe) fe_cnt++;
    if (ov) ov_cnt++;
    if (stb && !stb_prev) t_rise = cyc;
    stb_prev = stb;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(T);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(T);
    end
    rx = stop;
    idle(T);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    ack2 = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    ack2 = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_pulses", {30'd0, fe, ov}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    t0 = cyc;
    send(8'hA5, 1'b1);
    chk("a5_latency", t_rise - t0, 32'd155);
    chk("a5_stb", {31'd0, stb}, 32'd1);
    chk("a5_data", {24'd0, data}, 32'hA5);
    chk("a5_no_pulse", fe_cnt + ov_cnt, 32'd0);
    pulse_ack();
    chk("a5_ack_clr", {31'd0, stb}, 32'd0);
    idle(10);

    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    chk("glitch_stb", {31'd0, stb}, 32'd0);
    chk("glitch_pulses", fe_cnt + ov_cnt, 32'd0);

    send(8'h3C, 1'b0);
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(20);
    chk("fe_count", fe_cnt, 32'd1);
    chk("fe_no_stb", {31'd0, stb}, 32'd0);
    send(8'h81, 1'b1);
    idle(4);
    chk("81_stb", {31'd0, stb}, 32'd1);
    chk("81_data", {24'd0, data}, 32'h81);
    chk("81_fe_once", fe_cnt, 32'd1);
    pulse_ack();
    idle(10);

    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(4);
    chk("ov_count", ov_cnt, 32'd1);
    chk("ov_data", {24'd0, data}, 32'h11);
    chk("ov_stb", {31'd0, stb}, 32'd1);
    pulse_ack();
    idle(10);

    send(8'h11, 1'b1);
    fork
      send(8'h22, 1'b1);
      begin
        idle(154);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    idle(4);
    chk("ack_ov_none", ov_cnt, 32'd1);
    chk("ack_data", {24'd0, data}, 32'h22);
    chk("ack_stb", {31'd0, stb}, 32'd1);

    ov_base = ov_cnt;
    fork
      send(8'hFF, 1'b1);
      begin
        idle(T * 4 + 8);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stb", {31'd0, stb}, 32'd0);
        chk("mid_rst_data", {24'd0, data}, 32'd0);
        chk("mid_rst_pulses", {30'd0, fe, ov}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    idle(20);
    chk("rst_abort_ov", ov_cnt - ov_base, 32'd0);
    chk("rst_abort_stb", {31'd0, stb}, 32'd0);
    send(8'h5A, 1'b1);
    idle(4);
    chk("5a_stb", {31'd0, stb}, 32'd1);
    chk("5a_data", {24'd0, data}, 32'h5A);
    pulse_ack();
    idle(10);

    send(8'hF0, 1'b1);
    idle(4);
    chk("inv_stb", {31'd0, stb2}, 32'd1);
    chk("inv_data", {24'd0, data2}, 32'h0F);
    chk("plain_data", {24'd0, data}, 32'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
